// File: rtl/jk_bank_driver_pkg.sv
// jk_bank_driver_pkg
//   Shared types for the JK latch-bank driver: FSM state encoding and the
//   per-bit J/K excitation codes, plus a helper that picks the code for one
//   bit transition.
//   Build option: JK_BANK_DRIVER_TOGGLE_EN (consumed by jk_excite).
package jk_bank_driver_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } jkd_state_e;

  // Code value is {j, k}.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_code_e;

  function automatic jk_code_e jk_code(input logic cur, input logic tgt,
                                       input logic toggle_mode);
    if (cur == tgt) return JK_HOLD;
    if (toggle_mode) return JK_TOGGLE;
    return tgt ? JK_SET : JK_RESET;
  endfunction

endpackage

// File: rtl/jk_excite.sv
// jk_excite
//   Combinational J/K excitation for a bank of JK latches, moving each bit
//   from cur to tgt. Unchanged bits hold (j=k=0).
//   Build option: JK_BANK_DRIVER_TOGGLE_EN selects toggle encoding (j=k=1)
//   for changed bits; otherwise set/reset encoding (j&k never both 1).
// Ports:
//   cur [WIDTH] : present bank contents
//   tgt [WIDTH] : requested bank contents
//   j   [WIDTH] : J inputs
//   k   [WIDTH] : K inputs
module jk_excite
  import jk_bank_driver_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

`ifdef JK_BANK_DRIVER_TOGGLE_EN
  localparam logic TOGGLE_MODE = 1'b1;
`else
  localparam logic TOGGLE_MODE = 1'b0;
`endif

  always_comb begin
    j = '0;
    k = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      logic [1:0] code;
      code = jk_code(cur[i], tgt[i], TOGGLE_MODE);
      j[i] = code[1];
      k[i] = code[0];
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver
//   Drives an external bank of JK latches to a requested value: accepts a
//   target word, pulses en for one cycle with the J/K excitation, waits
//   SETTLE_CYCLES, then reads back q_fb, reports done (and err on mismatch)
//   and adopts the readback as its shadow copy cur_q. A target equal to
//   cur_q skips the drive and goes straight to the readback check.
//   Build option: JK_BANK_DRIVER_TOGGLE_EN (see jk_excite).
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   tgt_valid/tgt_ready : target handshake (ready only in IDLE)
//   tgt_data [WIDTH]    : requested bank value
//   j, k [WIDTH], en    : latch-bank drive, nonzero only in DRIVE
//   q_fb [WIDTH]        : bank readback
//   cur_q [WIDTH]       : shadow of bank contents
//   done, err           : one-cycle completion / readback-mismatch pulses
module jk_bank_driver
  import jk_bank_driver_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             en,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] cur_q,
  output logic             done,
  output logic             err
);

  localparam int unsigned CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

  jkd_state_e       state_q,   state_d;
  logic [WIDTH-1:0] tgt_reg_q, tgt_reg_d;
  logic [WIDTH-1:0] shadow_q,  shadow_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] j_q,       j_d;
  logic [WIDTH-1:0] k_q,       k_d;
  logic             en_q,      en_d;
  logic [WIDTH-1:0] exc_j,     exc_k;

  // Excitation is evaluated against the incoming word so that j/k/en can be
  // registered at the handshake edge and appear during the DRIVE cycle.
  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .cur (shadow_q),
    .tgt (tgt_data),
    .j   (exc_j),
    .k   (exc_k)
  );

  always_comb begin
    state_d   = state_q;
    tgt_reg_d = tgt_reg_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    j_d       = '0;
    k_d       = '0;
    en_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          tgt_reg_d = tgt_data;
          if (tgt_data == shadow_q) begin
            state_d = CHECK;
          end else begin
            state_d = DRIVE;
            en_d    = 1'b1;
            j_d     = exc_j;
            k_d     = exc_k;
          end
        end
      end
      DRIVE: begin
        if (SETTLE_CYCLES == 0) begin
          state_d = CHECK;
        end else begin
          state_d = SETTLE;
          cnt_d   = CNT_LOAD;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - CW'(1);
      end
      CHECK: begin
        shadow_d = q_fb;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tgt_reg_q <= '0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_reg_q <= tgt_reg_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      en_q      <= en_d;
    end
  end

  // done/err decode the registered state; err must see q_fb during CHECK
  // because the bank only updates at the edge closing the DRIVE cycle.
  assign tgt_ready = (state_q == IDLE);
  assign done      = (state_q == CHECK);
  assign err       = done && (q_fb != tgt_reg_q);
  assign j         = j_q;
  assign k         = k_q;
  assign en        = en_q;
  assign cur_q     = shadow_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver
//   Self-checking bench for jk_bank_driver (WIDTH=8, SETTLE_CYCLES=2). A JK
//   latch bank (with optional stuck-at-0 bits) closes the loop; a
//   transaction-level reference model predicts j/k, latency, done/err and
//   cur_q. Honours JK_BANK_DRIVER_TOGGLE_EN like the design.
module tb_jk_bank_driver;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tgt_valid = 1'b0;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data = '0;
  logic [WIDTH-1:0] j, k, q_fb, cur_q;
  logic             en, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_done_cyc = -100;
  logic last_err = 1'b0;

  logic [WIDTH-1:0] bank   = '0;
  logic [WIDTH-1:0] stuck0 = '0;
  logic [WIDTH-1:0] m_cur  = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical latch bank: JK behaviour per bit, clocked by en.
  always @(posedge clk) begin
    logic [WIDTH-1:0] nb;
    nb = bank;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({j[i], k[i]})
          2'b01:   nb[i] = 1'b0;
          2'b10:   nb[i] = 1'b1;
          2'b11:   nb[i] = ~bank[i];
          default: nb[i] = bank[i];
        endcase
      end
    end
    bank <= nb;
  end
  assign q_fb = bank & ~stuck0;

  jk_bank_driver #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .j         (j),
    .k         (k),
    .en        (en),
    .q_fb      (q_fb),
    .cur_q     (cur_q),
    .done      (done),
    .err       (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("en_while_ready", 32'(en & tgt_ready), 32'd0);
      if (!en) check_eq("jk_quiet", 32'({j, k}), 32'd0);
`ifndef JK_BANK_DRIVER_TOGGLE_EN
      check_eq("j_and_k", 32'(j & k), 32'd0);
`endif
      if (!done) check_eq("err_without_done", 32'(err), 32'd0);
    end
  end

  // One target transaction, checked cycle by cycle against the model.
  // keep: leave tgt_valid high afterwards; b2b: expect acceptance the cycle
  // after the previous done.
  task automatic run_txn(input logic [WIDTH-1:0] t, input bit keep, input bit b2b);
    int waited;
    logic [WIDTH-1:0] ej, ek;
    bit skip;
    waited = 0;
    while (!tgt_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!tgt_ready) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
      tgt_valid = 1'b0;
      return;
    end
    if (b2b) check_eq("b2b_accept_cycle", 32'(cyc), 32'(last_done_cyc + 1));
    tgt_valid = 1'b1;
    tgt_data  = t;
    skip = (t == m_cur);
`ifdef JK_BANK_DRIVER_TOGGLE_EN
    ej = t ^ m_cur;
    ek = t ^ m_cur;
`else
    ej = t & ~m_cur;
    ek = ~t & m_cur;
`endif
    @(negedge clk);
    if (!keep) tgt_valid = 1'b0;
    if (skip) begin
      check_eq("skip_done", 32'(done), 32'd1);
      check_eq("skip_no_en", 32'(en), 32'd0);
    end else begin
      check_eq("drive_en", 32'(en), 32'd1);
      check_eq("drive_j", 32'(j), 32'(ej));
      check_eq("drive_k", 32'(k), 32'(ek));
      check_eq("drive_no_done", 32'(done), 32'd0);
      check_eq("drive_not_ready", 32'(tgt_ready), 32'd0);
      repeat (SETTLE) begin
        @(negedge clk);
        check_eq("settle_en", 32'(en), 32'd0);
        check_eq("settle_no_done", 32'(done), 32'd0);
        check_eq("settle_not_ready", 32'(tgt_ready), 32'd0);
      end
      @(negedge clk);
      check_eq("done", 32'(done), 32'd1);
    end
    check_eq("err", 32'(err), 32'(q_fb != t));
    last_err      = err;
    last_done_cyc = cyc;
    m_cur         = q_fb;
    @(negedge clk);
    check_eq("cur_q", 32'(cur_q), 32'(m_cur));
    check_eq("ready_after", 32'(tgt_ready), 32'd1);
    check_eq("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit prev_keep;
    bit keep;
    logic [WIDTH-1:0] t;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", 32'({en, done, err}), 32'd0);
    check_eq("rst_jk", 32'({j, k}), 32'd0);
    check_eq("rst_cur", 32'(cur_q), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(tgt_ready), 32'd1);

    // Directed: first drive, full change, skip, stuck bit
    run_txn(8'hA5, 1'b0, 1'b0);
    check_eq("a5_cur", 32'(cur_q), 32'hA5);
    run_txn(8'h5A, 1'b0, 1'b0);
    check_eq("5a_cur", 32'(cur_q), 32'h5A);
    run_txn(8'h5A, 1'b0, 1'b0);
    check_eq("skip_err", 32'(last_err), 32'd0);
    stuck0 = 8'h01;
    run_txn(8'h01, 1'b0, 1'b0);
    check_eq("stuck_err", 32'(last_err), 32'd1);
    check_eq("stuck_cur", 32'(cur_q), 32'h00);
    stuck0 = '0;

    // Reset during SETTLE aborts with no done/err
    while (!tgt_ready) @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data  = ~m_cur;
    @(negedge clk);
    tgt_valid = 1'b0;
    check_eq("abort_en", 32'(en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_outputs", 32'({en, done, err}), 32'd0);
    check_eq("abort_jk", 32'({j, k}), 32'd0);
    check_eq("abort_cur", 32'(cur_q), 32'd0);
    rst_n = 1'b1;
    m_cur = '0;
    @(negedge clk);
    check_eq("abort_ready", 32'(tgt_ready), 32'd1);
    check_eq("abort_no_done", 32'(done), 32'd0);

    // Back-to-back with tgt_valid held high
    run_txn(8'h0F, 1'b1, 1'b0);
    run_txn(8'hF0, 1'b0, 1'b1);

    // Randomized targets, occasional repeats, stuck bits and held valid
    prev_keep = 1'b0;
    for (int n = 0; n < 40; n++) begin
      t = WIDTH'($urandom);
      if ($urandom_range(0, 5) == 0) t = m_cur;
      stuck0 = ($urandom_range(0, 4) == 0) ? WIDTH'(1 << $urandom_range(0, WIDTH - 1)) : '0;
      keep = (n < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn(t, keep, prev_keep);
      prev_keep = keep;
    end
    tgt_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
